// File: rtl/mem_bus_pkg.sv
// Shared definitions for the picorv32-native memory bus and the arbiter FSM.
package mem_bus_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   localparam logic [1:0] ST_IDLE_ENC = 2'd0;
   localparam logic [1:0] ST_BUSY_ENC = 2'd1;
   localparam logic [1:0] ST_DONE_ENC = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = ST_IDLE_ENC,
      ST_BUSY = ST_BUSY_ENC,
      ST_DONE = ST_DONE_ENC
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker: on a tie the requester that was not served last wins.
module rr_arbiter2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       sel_o,
   output logic       any_o
);

   always_comb begin
      any_o = |req_i;
      if (req_i == 2'b11) begin
         sel_o = ~last_i;
      end else begin
         sel_o = req_i[1];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sharing of one picorv32 memory port between two cores, with a
// turnaround cycle after every access and a watchdog for unacknowledged accesses.
module mem_arbiter
   import mem_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_valid,
   output logic              m0_ready,
   input  logic              m0_instr,
   input  logic [STRB_W-1:0] m0_wstrb,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_valid,
   output logic              m1_ready,
   input  logic              m1_instr,
   input  logic [STRB_W-1:0] m1_wstrb,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [ADDR_W-1:0] m1_addr,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_instr,
   output logic [STRB_W-1:0] mem_wstrb,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        grant,
   output logic              timeout_err
);

   localparam int unsigned WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : WD_W'(TIMEOUT_CYCLES - 1);
   localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

   arb_state_e        state_q;
   logic              sel_q;
   logic              last_q;
   logic [WD_W-1:0]   wd_q;
   logic [DATA_W-1:0] rdata_q;
   logic              terr_q;

   logic              pick_sel;
   logic              pick_any;
   logic              busy;
   logic              done;

   rr_arbiter2 u_rr (
      .req_i  ({m1_valid, m0_valid}),
      .last_i (last_q),
      .sel_o  (pick_sel),
      .any_o  (pick_any)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sel_q   <= 1'b0;
         last_q  <= 1'b1;
         wd_q    <= '0;
         rdata_q <= '0;
         terr_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               wd_q <= '0;
               if (pick_any) begin
                  sel_q   <= pick_sel;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // A real acknowledge always beats a watchdog expiry in the same cycle.
               if (mem_ready) begin
                  rdata_q <= mem_rdata;
                  last_q  <= sel_q;
                  state_q <= ST_DONE;
               end else if (WD_EN && (wd_q == WD_LAST)) begin
                  rdata_q <= ERR_DATA;
                  terr_q  <= 1'b1;
                  last_q  <= sel_q;
                  state_q <= ST_DONE;
               end else if (WD_EN) begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            ST_DONE: begin
               wd_q    <= '0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state_q == ST_BUSY);
   assign done = (state_q == ST_DONE);

   assign mem_valid   = busy;
   assign mem_instr   = busy & (sel_q ? m1_instr : m0_instr);
   assign mem_wstrb   = busy ? (sel_q ? m1_wstrb : m0_wstrb) : '0;
   assign mem_wdata   = busy ? (sel_q ? m1_wdata : m0_wdata) : '0;
   assign mem_addr    = busy ? (sel_q ? m1_addr  : m0_addr)  : '0;
   assign grant       = busy ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
   assign timeout_err = terr_q;

   assign m0_ready = done & ~sel_q;
   assign m1_ready = done &  sel_q;
   assign m0_rdata = (done & ~sel_q) ? rdata_q : '0;
   assign m1_rdata = (done &  sel_q) ? rdata_q : '0;

endmodule
